// File: rtl/page_reg_pkg.sv
// Shared types for the page-register write sequencer.
// Lane geometry, sequencer states and the queued command record.
package page_reg_pkg;

    localparam int LANES   = 4;
    localparam int LANE_W  = 8;
    localparam int DATA_W  = LANES * LANE_W;
    localparam int PAGE_FW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STROBE
    } state_t;

    typedef struct packed {
        logic               wr;
        logic [PAGE_FW-1:0] page;
        logic [DATA_W-1:0]  data;
        logic [LANES-1:0]   be;
    } cmd_t;

endpackage

// File: rtl/page_cmd_fifo.sv
// Command FIFO with registered flags.
// ready is a flop that stays low through reset.
module page_cmd_fifo
    import page_reg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic empty,
    output logic empty_nxt,
    output logic ready
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_nxt;
    logic [AW:0]    rd_nxt;
    logic           full;
    logic           full_nxt;
    logic           do_push;
    logic           do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign wr_nxt    = wr_ptr + (AW+1)'(do_push);
    assign rd_nxt    = rd_ptr + (AW+1)'(do_pop);
    assign empty_nxt = (wr_nxt == rd_nxt);
    assign full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) &&
                       (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    assign dout      = mem[rd_ptr[AW-1:0]];

    // Pointers and flags advance together; the extra MSB tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= full_nxt;
            empty  <= empty_nxt;
            ready  <= !full_nxt;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/page_reg_wr_ctrl.sv
// Write sequencer for the four page-register byte banks.
// Data is placed on the bus one cycle before the enables pulse.
module page_reg_wr_ctrl
    import page_reg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PAGES = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic                     REQ_WR,
    input  logic [$clog2(PAGES)-1:0] REQ_PAGE,
    input  logic [DATA_W-1:0]        REQ_DATA,
    input  logic [LANES-1:0]         REQ_BE,
    output logic [DATA_W-1:0]        DATA_RES,
    output logic [PAGES-1:0]         EN_B0,
    output logic [PAGES-1:0]         EN_B1,
    output logic [PAGES-1:0]         EN_B2,
    output logic [PAGES-1:0]         EN_B3,
    output logic [PAGES-1:0]         PAGE_SEL,
    output logic                     BUSY
);

    localparam int PW = $clog2(PAGES);
    localparam logic [PAGES-1:0] OH0 = {{(PAGES-1){1'b0}}, 1'b1};

    state_t                        state;
    cmd_t                          cmd_in;
    cmd_t                          head;
    logic                          push;
    logic                          pop;
    logic                          empty;
    logic                          empty_nxt;
    logic                          page_ok;
    logic                          wr_go;
    logic                          sel_go;
    logic [PAGES-1:0]              page_oh;
    logic [PAGES-1:0]              pg_q;
    logic [LANES-1:0]              be_q;
    logic [LANES-1:0][PAGES-1:0]   en_q;

    assign cmd_in = '{
        wr:   REQ_WR,
        page: PAGE_FW'(REQ_PAGE),
        data: REQ_DATA,
        be:   REQ_BE
    };

    assign push    = REQ_VALID && REQ_READY;
    assign pop     = (state == IDLE) && !empty;
    assign page_ok = int'(head.page) < PAGES;
    assign page_oh = OH0 << head.page[PW-1:0];
    assign wr_go   = pop && head.wr && (head.be != '0) && page_ok;
    assign sel_go  = pop && !head.wr && page_ok;

    assign EN_B0 = en_q[0];
    assign EN_B1 = en_q[1];
    assign EN_B2 = en_q[2];
    assign EN_B3 = en_q[3];

    page_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .pop      (pop),
        .din      (cmd_in),
        .dout     (head),
        .empty    (empty),
        .empty_nxt(empty_nxt),
        .ready    (REQ_READY)
    );

    // Sequencer: pop in IDLE, enables pulse for the single STROBE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            DATA_RES <= '0;
            en_q     <= '0;
            PAGE_SEL <= OH0;
            pg_q     <= '0;
            be_q     <= '0;
            BUSY     <= 1'b0;
        end else begin
            BUSY <= !empty_nxt || wr_go || (state == ARM);
            unique case (state)
                IDLE: begin
                    if (wr_go) begin
                        DATA_RES <= head.data;
                        pg_q     <= page_oh;
                        be_q     <= head.be;
                        state    <= ARM;
                    end else if (sel_go) begin
                        PAGE_SEL <= page_oh;
                    end
                end
                ARM: begin
                    for (int n = 0; n < LANES; n++) begin
                        en_q[n] <= be_q[n] ? pg_q : '0;
                    end
                    state <= STROBE;
                end
                STROBE: begin
                    en_q  <= '0;
                    state <= IDLE;
                end
                default: begin
                    en_q  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_page_reg_wr_ctrl.sv
// Bench for page_reg_wr_ctrl: directed table, corner sequences and
// random traffic checked against a transaction-level reference.
module tb_page_reg_wr_ctrl;

    localparam int DEPTH = 4;
    localparam int PAGES = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_WR = 1'b0;
    logic [2:0]  REQ_PAGE = '0;
    logic [31:0] REQ_DATA = '0;
    logic [3:0]  REQ_BE = '0;
    logic        REQ_READY;
    logic        BUSY;
    logic [31:0] DATA_RES;
    logic [7:0]  EN_B0;
    logic [7:0]  EN_B1;
    logic [7:0]  EN_B2;
    logic [7:0]  EN_B3;
    logic [7:0]  PAGE_SEL;

    page_reg_wr_ctrl #(
        .DEPTH(DEPTH),
        .PAGES(PAGES)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WR   (REQ_WR),
        .REQ_PAGE (REQ_PAGE),
        .REQ_DATA (REQ_DATA),
        .REQ_BE   (REQ_BE),
        .DATA_RES (DATA_RES),
        .EN_B0    (EN_B0),
        .EN_B1    (EN_B1),
        .EN_B2    (EN_B2),
        .EN_B3    (EN_B3),
        .PAGE_SEL (PAGE_SEL),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] en_all();
        return {EN_B3, EN_B2, EN_B1, EN_B0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted commands and a per-write timeline
    // (pop -> enables one cycle later -> enables off one cycle after that).
    typedef struct {
        bit        wr;
        int        page;
        bit [31:0] data;
        bit [3:0]  be;
    } mcmd_t;

    mcmd_t     q[$];
    int        age = 0;
    bit        m_ready = 0;
    bit        m_busy = 0;
    bit [31:0] m_data = 0;
    bit [31:0] m_en = 0;
    bit [31:0] m_pend = 0;
    bit [7:0]  m_sel = 8'h01;

    task automatic model_step();
        mcmd_t c;
        bit    acc;
        if (RST) begin
            q.delete();
            age = 0; m_ready = 0; m_busy = 0;
            m_data = 0; m_en = 0; m_sel = 8'h01;
            return;
        end
        acc = REQ_VALID && m_ready;
        if (age == 1) begin
            m_en = m_pend; age = 2;
        end else if (age == 2) begin
            m_en = 0; age = 0;
        end else if (q.size() != 0) begin
            c = q.pop_front();
            if (c.wr && c.be != 0 && c.page < PAGES) begin
                m_data = c.data;
                m_pend = 0;
                for (int n = 0; n < 4; n++)
                    if (c.be[n]) m_pend[n*8 +: 8] = 8'(1 << c.page);
                age = 1;
            end else if (!c.wr && c.page < PAGES) begin
                m_sel = 8'(1 << c.page);
            end
        end
        if (acc) begin
            c.wr = REQ_WR; c.page = int'(REQ_PAGE);
            c.data = REQ_DATA; c.be = REQ_BE;
            q.push_back(c);
        end
        m_ready = (q.size() != DEPTH);
        m_busy  = (q.size() != 0) || (age != 0);
    endtask

    always @(posedge CLK or posedge RST) model_step();

    bit mon_on = 0;
    int strobe_cyc[$];

    always @(negedge CLK) begin
        chk("ready", 32'(REQ_READY), 32'(m_ready));
        chk("busy", 32'(BUSY), 32'(m_busy));
        chk("data_res", DATA_RES, m_data);
        chk("en", en_all(), m_en);
        chk("page_sel", 32'(PAGE_SEL), 32'(m_sel));
        if (mon_on && en_all() != 0) strobe_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(bit wr, int page, bit [31:0] data, bit [3:0] be);
        bit ok = 0;
        REQ_VALID = 1; REQ_WR = wr; REQ_PAGE = 3'(page);
        REQ_DATA = data; REQ_BE = be;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = REQ_READY;
            tick();
        end
        REQ_VALID = 0;
        chk("accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && BUSY; t++) tick();
        chk("idle", 32'(BUSY), 32'd0);
    endtask

    task automatic burst(int n, output int acc, output bit low);
        bit ok;
        acc = 0; low = 0;
        REQ_VALID = 1; REQ_WR = 1; REQ_BE = 4'hF;
        REQ_PAGE = 3'(0); REQ_DATA = 32'h5000_0000;
        for (int t = 0; t < 300 && acc < n; t++) begin
            ok = REQ_READY;
            if (!ok) low = 1;
            tick();
            if (ok) begin
                acc++;
                REQ_PAGE = 3'(acc);
                REQ_DATA = 32'h5000_0000 + 32'(acc);
            end
        end
        REQ_VALID = 0;
    endtask

    typedef struct {
        bit        wr;
        int        page;
        bit [31:0] data;
        bit [3:0]  be;
        bit [31:0] e_data;
        bit [31:0] e_en;
        bit [7:0]  e_sel;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  acc;
        bit  low;
        int  bcyc;

        vt[0] = '{1, 3, 32'hA1B2C3D4, 4'hF, 32'hA1B2C3D4, 32'h08080808, 8'h01};
        vt[1] = '{1, 5, 32'h11223344, 4'h5, 32'h11223344, 32'h00200020, 8'h01};
        vt[2] = '{1, 0, 32'hDEADBEEF, 4'h0, 32'h11223344, 32'h00000000, 8'h01};
        vt[3] = '{0, 6, 32'h0,        4'h0, 32'h11223344, 32'h00000000, 8'h40};
        vt[4] = '{1, 7, 32'hCAFEF00D, 4'h8, 32'hCAFEF00D, 32'h80000000, 8'h40};
        vt[5] = '{0, 0, 32'h0,        4'h0, 32'hCAFEF00D, 32'h00000000, 8'h01};
        vt[6] = '{1, 0, 32'h0000AB00, 4'h2, 32'h0000AB00, 32'h00000100, 8'h01};

        #1 RST = 1;
        repeat (3) tick();
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_data", DATA_RES, 32'd0);
        chk("rst_en", en_all(), 32'd0);
        chk("rst_sel", 32'(PAGE_SEL), 32'h01);
        @(negedge CLK) RST = 0;
        tick();
        chk("ready_after_rst", 32'(REQ_READY), 32'd1);

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            tick();
            send(vt[i].wr, vt[i].page, vt[i].data, vt[i].be);
            tick();
            chk($sformatf("vec%0d_data", i), DATA_RES, vt[i].e_data);
            tick();
            chk($sformatf("vec%0d_en", i), en_all(), vt[i].e_en);
            tick();
            chk($sformatf("vec%0d_en_off", i), en_all(), 32'd0);
            chk($sformatf("vec%0d_sel", i), 32'(PAGE_SEL), 32'(vt[i].e_sel));
        end

        wait_idle();
        strobe_cyc.delete();
        mon_on = 1;
        burst(8, acc, low);
        chk("b2b_accepts", 32'(acc), 32'd8);
        chk("b2b_ready_dropped", 32'(low), 32'd1);
        bcyc = -1;
        for (int t = 0; t < 200 && bcyc < 0; t++) begin
            @(negedge CLK);
            if (!BUSY) bcyc = cyc;
        end
        mon_on = 0;
        tick();
        chk("b2b_strobes", 32'(strobe_cyc.size()), 32'd8);
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk("b2b_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd3);
        if (strobe_cyc.size() > 0)
            chk("busy_fall", 32'(bcyc - strobe_cyc[$]), 32'd1);

        wait_idle();
        send(1, 1, 32'h0BAD_F00D, 4'hF);
        send(0, 6, 32'h0, 4'h0);
        for (int t = 0; t < 20 && EN_B0 == 0; t++) tick();
        chk("ws_strobe_seen", 32'(EN_B0), 32'h02);
        chk("ws_sel_at_strobe", 32'(PAGE_SEL), 32'h01);
        tick();
        chk("ws_sel_after_strobe", 32'(PAGE_SEL), 32'h01);
        tick();
        chk("ws_sel_new", 32'(PAGE_SEL), 32'h40);

        wait_idle();
        burst(5, acc, low);
        chk("arm_busy", 32'(BUSY), 32'd1);
        RST = 1;
        #1;
        chk("mid_rst_en", en_all(), 32'd0);
        chk("mid_rst_sel", 32'(PAGE_SEL), 32'h01);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_ready", 32'(REQ_READY), 32'd0);
        repeat (2) tick();
        @(negedge CLK) RST = 0;
        tick();
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        repeat (6) tick();
        chk("post_rst_quiet", en_all(), 32'd0);

        for (int t = 0; t < 400; t++) begin
            REQ_VALID = ($urandom_range(0, 99) < 60);
            REQ_WR    = ($urandom_range(0, 3) != 0);
            REQ_PAGE  = 3'($urandom_range(0, 7));
            REQ_DATA  = $urandom;
            REQ_BE    = 4'($urandom_range(0, 15));
            tick();
        end
        REQ_VALID = 0;
        wait_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
